oram_req_arbiter: RTL and testbench

ORAM_REQ_ARBITER -- requirements
Module: oram_req_arbiter

---
 rtl/oram_req_arbiter_pkg.sv | 27 ++
 rtl/oram_req_arbiter_rr_pick.sv | 32 +++
 rtl/oram_req_arbiter.sv | 170 +++++++++++++++++
 tb/tb_oram_req_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oram_req_arbiter_pkg.sv
// Shared ORAM constants: backend command encodings, arbiter FSM states and
// small command classification helpers.
package oram_req_arbiter_pkg;

  localparam logic [1:0] BECMD_Update  = 2'd0;
  localparam logic [1:0] BECMD_Append  = 2'd1;
  localparam logic [1:0] BECMD_Read    = 2'd2;
  localparam logic [1:0] BECMD_ReadRmv = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_WDATA = 2'd2,
    ST_RDATA = 2'd3
  } arb_state_e;

  // Commands that carry a block of write data toward the controller.
  function automatic logic becmd_is_write(input logic [1:0] cmd);
    return (cmd == BECMD_Update) || (cmd == BECMD_Append);
  endfunction

  // Commands that return a block of data from the controller.
  function automatic logic becmd_is_read(input logic [1:0] cmd);
    return (cmd == BECMD_Read) || (cmd == BECMD_ReadRmv);
  endfunction

endpackage

// File: rtl/oram_req_arbiter_rr_pick.sv
// Round-robin selector: finds the first requester at or after prio,
// wrapping from NumReq-1 back to 0, and returns it as index and one-hot.
module rr_pick #(
  parameter int NumReq = 4,
  parameter int IdxW   = 2
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   prio,
  output logic              any,
  output logic [IdxW-1:0]   idx,
  output logic [NumReq-1:0] onehot
);

  logic [IdxW-1:0] cand;

  // Scan candidates in rotated order; the first hit wins.
  always_comb begin
    any    = 1'b0;
    idx    = '0;
    onehot = '0;
    cand   = '0;
    for (int i = 0; i < NumReq; i++) begin
      cand = IdxW'((int'(prio) + i) % NumReq);
      if (!any && req[cand]) begin
        any          = 1'b1;
        idx          = cand;
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/oram_req_arbiter.sv
// Arbitrates several network requesters onto one ORAM controller. A granted
// requester owns the controller for one command plus one full block of
// write or read data; valid/ready are passed through combinationally so a
// chunk can move every cycle.
module oram_req_arbiter
  import oram_req_arbiter_pkg::*;
#(
  parameter int NumReq            = 4,
  parameter int FEDWidth          = 64,
  parameter int BECMDWidth        = 2,
  parameter int ORAMU             = 32,
  parameter int BlkSize_FEDChunks = 8
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic [NumReq-1:0]            ReqCmdValid,
  output logic [NumReq-1:0]            ReqCmdReady,
  input  logic [NumReq*BECMDWidth-1:0] ReqCmd,
  input  logic [NumReq*ORAMU-1:0]      ReqAddr,
  input  logic [NumReq-1:0]            ReqDataValid,
  output logic [NumReq-1:0]            ReqDataReady,
  input  logic [NumReq*FEDWidth-1:0]   ReqData,
  output logic [NumReq-1:0]            RespDataValid,
  input  logic [NumReq-1:0]            RespDataReady,
  output logic [FEDWidth-1:0]          RespData,
  output logic                         OCmdValid,
  input  logic                         OCmdReady,
  output logic [BECMDWidth-1:0]        OCmd,
  output logic [ORAMU-1:0]             OAddr,
  output logic                         ODataValid,
  input  logic                         ODataReady,
  output logic [FEDWidth-1:0]          OData,
  input  logic                         ORetValid,
  output logic                         ORetReady,
  input  logic [FEDWidth-1:0]          ORetData,
  output logic [NumReq-1:0]            Grant
);

  localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int CntW = $clog2(BlkSize_FEDChunks + 1);

  arb_state_e        state, state_n;
  logic [IdxW-1:0]   owner, owner_n;
  logic [IdxW-1:0]   prio, prio_n;
  logic [NumReq-1:0] grant, grant_n;
  logic [CntW-1:0]   cnt, cnt_n;

  logic              pick_any;
  logic [IdxW-1:0]   pick_idx;
  logic [NumReq-1:0] pick_onehot;

  logic [BECMDWidth-1:0] cmd_arr  [NumReq];
  logic [ORAMU-1:0]      addr_arr [NumReq];
  logic [FEDWidth-1:0]   data_arr [NumReq];

  rr_pick #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_rr_pick (
    .req    (ReqCmdValid),
    .prio   (prio),
    .any    (pick_any),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  // Unpack the per-requester buses so the owner can index them directly.
  always_comb begin
    for (int p = 0; p < NumReq; p++) begin
      cmd_arr[p]  = ReqCmd[p*BECMDWidth +: BECMDWidth];
      addr_arr[p] = ReqAddr[p*ORAMU +: ORAMU];
      data_arr[p] = ReqData[p*FEDWidth +: FEDWidth];
    end
  end

  // Data paths always follow the owner; only the handshakes are gated by state.
  assign OCmd     = cmd_arr[owner];
  assign OAddr    = addr_arr[owner];
  assign OData    = data_arr[owner];
  assign RespData = ORetData;
  assign Grant    = grant;

  // Next-state, ownership bookkeeping and handshake steering.
  always_comb begin
    state_n       = state;
    owner_n       = owner;
    prio_n        = prio;
    grant_n       = grant;
    cnt_n         = cnt;
    OCmdValid     = 1'b0;
    ODataValid    = 1'b0;
    ORetReady     = 1'b0;
    ReqCmdReady   = '0;
    ReqDataReady  = '0;
    RespDataValid = '0;
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          state_n = ST_CMD;
          owner_n = pick_idx;
          grant_n = pick_onehot;
          prio_n  = (pick_idx == IdxW'(NumReq - 1)) ? '0 : pick_idx + IdxW'(1);
        end
      end
      ST_CMD: begin
        OCmdValid          = 1'b1;
        ReqCmdReady[owner] = OCmdReady;
        if (OCmdReady) begin
          if (becmd_is_write(2'(OCmd))) begin
            state_n = ST_WDATA;
          end else if (becmd_is_read(2'(OCmd))) begin
            state_n = ST_RDATA;
          end else begin
            state_n = ST_IDLE;
            grant_n = '0;
          end
        end
      end
      ST_WDATA: begin
        ODataValid          = ReqDataValid[owner];
        ReqDataReady[owner] = ODataReady;
        if (ReqDataValid[owner] && ODataReady) begin
          if (cnt == CntW'(BlkSize_FEDChunks - 1)) begin
            cnt_n   = '0;
            state_n = ST_IDLE;
            grant_n = '0;
          end else begin
            cnt_n = cnt + CntW'(1);
          end
        end
      end
      ST_RDATA: begin
        RespDataValid[owner] = ORetValid;
        ORetReady            = RespDataReady[owner];
        if (ORetValid && RespDataReady[owner]) begin
          if (cnt == CntW'(BlkSize_FEDChunks - 1)) begin
            cnt_n   = '0;
            state_n = ST_IDLE;
            grant_n = '0;
          end else begin
            cnt_n = cnt + CntW'(1);
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        grant_n = '0;
        cnt_n   = '0;
      end
    endcase
  end

  // Control state register with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= ST_IDLE;
      owner <= '0;
      prio  <= '0;
      grant <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      prio  <= prio_n;
      grant <= grant_n;
      cnt   <= cnt_n;
    end
  end

endmodule

// File: tb/tb_oram_req_arbiter.sv
// Scoreboard bench for oram_req_arbiter: stimulus pushes expected command,
// write-chunk and read-chunk transfers; a negedge monitor pops and compares.
module tb_oram_req_arbiter;
  import oram_req_arbiter_pkg::*;

  localparam int N   = 4;
  localparam int FW  = 64;
  localparam int CW  = 2;
  localparam int AW  = 32;
  localparam int BLK = 8;

  logic            Clock = 1'b0;
  logic            Reset;
  logic [N-1:0]    ReqCmdValid, ReqCmdReady;
  logic [N*CW-1:0] ReqCmd;
  logic [N*AW-1:0] ReqAddr;
  logic [N-1:0]    ReqDataValid, ReqDataReady;
  logic [N*FW-1:0] ReqData;
  logic [N-1:0]    RespDataValid, RespDataReady;
  logic [FW-1:0]   RespData;
  logic            OCmdValid, OCmdReady;
  logic [CW-1:0]   OCmd;
  logic [AW-1:0]   OAddr;
  logic            ODataValid, ODataReady;
  logic [FW-1:0]   OData;
  logic            ORetValid, ORetReady;
  logic [FW-1:0]   ORetData;
  logic [N-1:0]    Grant;

  oram_req_arbiter dut (
    .Clock(Clock), .Reset(Reset),
    .ReqCmdValid(ReqCmdValid), .ReqCmdReady(ReqCmdReady),
    .ReqCmd(ReqCmd), .ReqAddr(ReqAddr),
    .ReqDataValid(ReqDataValid), .ReqDataReady(ReqDataReady), .ReqData(ReqData),
    .RespDataValid(RespDataValid), .RespDataReady(RespDataReady), .RespData(RespData),
    .OCmdValid(OCmdValid), .OCmdReady(OCmdReady), .OCmd(OCmd), .OAddr(OAddr),
    .ODataValid(ODataValid), .ODataReady(ODataReady), .OData(OData),
    .ORetValid(ORetValid), .ORetReady(ORetReady), .ORetData(ORetData),
    .Grant(Grant)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [N-1:0]  g;
    logic [CW-1:0] c;
    logic [AW-1:0] a;
  } cmd_t;

  typedef struct packed {
    logic [N-1:0]  g;
    logic [FW-1:0] d;
  } dat_t;

  cmd_t exp_cmd_q[$];
  dat_t exp_wd_q[$];
  dat_t exp_rd_q[$];
  int   vectors = 0;
  int   errors  = 0;

  // Requester and controller model state.
  logic [FW-1:0] wdat [N][BLK];
  int            wptr [N];
  logic          wact [N];
  logic          hold [N];
  int            stall [N];
  logic          stall_arm [N];
  logic          tog;
  logic          ret_pend;
  logic [AW-1:0] ret_addr;
  int            ret_k;
  int            ncmd;
  int            ncmd_stop;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [127:0] act);
    vectors++;
    errors++;
    $display("FAIL %s: got transfer %h expected no transfer", name, act);
  endtask

  // Monitor: every handshake the DUT presents must match the next expectation.
  initial begin : monitor
    cmd_t ec;
    dat_t ed;
    forever begin
      @(negedge Clock);
      if (Reset !== 1'b1) begin
        if (OCmdValid && OCmdReady) begin
          if (exp_cmd_q.size() == 0) unexpected("cmd_extra", {Grant, OCmd, OAddr});
          else begin
            ec = exp_cmd_q.pop_front();
            check("cmd", {ReqCmdReady, Grant, OCmd, OAddr}, {ec.g, ec.g, ec.c, ec.a});
          end
        end
        if (ODataValid && ODataReady) begin
          if (exp_wd_q.size() == 0) unexpected("wdata_extra", {ReqDataReady, OData});
          else begin
            ed = exp_wd_q.pop_front();
            check("wdata", {ReqDataReady, OData}, {ed.g, ed.d});
          end
        end
        if (|(RespDataValid & RespDataReady)) begin
          if (exp_rd_q.size() == 0) unexpected("rdata_extra", {RespDataValid & RespDataReady, RespData});
          else begin
            ed = exp_rd_q.pop_front();
            check("rdata", {RespDataValid & RespDataReady, RespData}, {ed.g, ed.d});
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  task automatic drive();
    for (int p = 0; p < N; p++) begin
      ReqDataValid[p]       = wact[p] && (wptr[p] < BLK);
      ReqData[p*FW +: FW]   = wdat[p][(wptr[p] < BLK) ? wptr[p] : 0];
      RespDataReady[p]      = (stall[p] == 0);
    end
    ORetValid = ret_pend;
    ORetData  = {ret_addr, 32'(ret_k)};
  endtask

  task automatic step();
    logic [N-1:0]  chs, whs;
    logic          ohs, rhs;
    logic [CW-1:0] oc;
    logic [AW-1:0] oa;
    @(negedge Clock);
    chs = ReqCmdValid & ReqCmdReady;
    whs = ReqDataValid & ReqDataReady;
    ohs = OCmdValid && OCmdReady;
    rhs = ORetValid && ORetReady;
    oc  = OCmd;
    oa  = OAddr;
    if (stall[3] > 0) begin
      check("stall_oretready", {31'd0, ORetReady}, 32'd0);
      check("stall_respvalid", {28'd0, RespDataValid}, 32'h8);
    end
    @(posedge Clock);
    #1;
    for (int p = 0; p < N; p++) begin
      if (chs[p]) begin
        ncmd++;
        ReqCmdValid[p] = hold[p];
        if (stall_arm[p]) begin
          stall[p]     = 5;
          stall_arm[p] = 1'b0;
        end
      end else if (stall[p] > 0) begin
        stall[p]--;
      end
      if (whs[p]) wptr[p]++;
    end
    if (ohs && becmd_is_read(oc)) begin
      ret_pend = 1'b1;
      ret_addr = oa;
      ret_k    = 0;
    end
    if (rhs) begin
      ret_k++;
      if (ret_k == BLK) ret_pend = 1'b0;
    end
    ODataReady = tog ? ~ODataReady : 1'b1;
    if (ncmd_stop > 0 && ncmd == ncmd_stop) begin
      ReqCmdValid = '0;
      for (int p = 0; p < N; p++) hold[p] = 1'b0;
      ncmd_stop = 0;
    end
    drive();
  endtask

  task automatic issue(input int p, input logic [CW-1:0] c, input logic [AW-1:0] a);
    ReqCmd[p*CW +: CW]  = c;
    ReqAddr[p*AW +: AW] = a;
    ReqCmdValid[p]      = 1'b1;
  endtask

  task automatic expect_read(input int p, input logic [CW-1:0] c, input logic [AW-1:0] a);
    logic [N-1:0] g;
    g = '0;
    g[p] = 1'b1;
    exp_cmd_q.push_back('{g: g, c: c, a: a});
    for (int k = 0; k < BLK; k++) exp_rd_q.push_back('{g: g, d: {a, 32'(k)}});
  endtask

  task automatic load_write(input int p, input logic [FW-1:0] base);
    for (int k = 0; k < BLK; k++) wdat[p][k] = base + FW'(k);
    wptr[p] = 0;
    wact[p] = 1'b1;
  endtask

  task automatic expect_write(input int p, input logic [CW-1:0] c, input logic [AW-1:0] a,
                              input logic [FW-1:0] base, input int nchunks);
    logic [N-1:0] g;
    g = '0;
    g[p] = 1'b1;
    exp_cmd_q.push_back('{g: g, c: c, a: a});
    for (int k = 0; k < nchunks; k++) exp_wd_q.push_back('{g: g, d: base + FW'(k)});
  endtask

  task automatic wait_done(input string name, input int maxc);
    int n;
    n = 0;
    while (!(exp_cmd_q.size() == 0 && exp_wd_q.size() == 0 && exp_rd_q.size() == 0 &&
             Grant == '0 && ReqCmdValid == '0 && !ret_pend)) begin
      if (n >= maxc) begin
        vectors++;
        errors++;
        $display("FAIL timeout_%s: not finished after %0d cycles, required completion", name, maxc);
        exp_cmd_q.delete();
        exp_wd_q.delete();
        exp_rd_q.delete();
        ReqCmdValid = '0;
        break;
      end
      step();
      n++;
    end
  endtask

  initial begin : stim
    int n;
    Reset       = 1'b1;
    ReqCmdValid = '0;
    ReqCmd      = '0;
    ReqAddr     = '0;
    ReqData     = '0;
    OCmdReady   = 1'b1;
    ODataReady  = 1'b1;
    tog         = 1'b0;
    ret_pend    = 1'b0;
    ret_addr    = '0;
    ret_k       = 0;
    ncmd        = 0;
    ncmd_stop   = 0;
    for (int p = 0; p < N; p++) begin
      wptr[p] = 0; wact[p] = 1'b0; hold[p] = 1'b0; stall[p] = 0; stall_arm[p] = 1'b0;
      for (int k = 0; k < BLK; k++) wdat[p][k] = '0;
    end
    drive();
    repeat (3) step();
    check("reset_outs", {Grant, OCmdValid, ODataValid, ORetReady, ReqCmdReady, ReqDataReady, RespDataValid},
          '0);
    Reset = 1'b0;

    // Requesters 0 and 2 read together: 0 first, then 2.
    issue(0, BECMD_Read, 32'hA0);
    issue(2, BECMD_Read, 32'hA2);
    expect_read(0, BECMD_Read, 32'hA0);
    expect_read(2, BECMD_Read, 32'hA2);
    wait_done("rr_0_2", 80);

    // Pointer now 3: requesters 0 and 3 together must serve 3 first.
    issue(0, BECMD_Read, 32'hB0);
    issue(3, BECMD_Read, 32'hB3);
    expect_read(3, BECMD_Read, 32'hB3);
    expect_read(0, BECMD_Read, 32'hB0);
    wait_done("prio3", 80);

    // Requester 1 update with a toggling controller ready.
    load_write(1, 64'h11);
    tog = 1'b1;
    issue(1, BECMD_Update, 32'h51);
    expect_write(1, BECMD_Update, 32'h51, 64'h11, BLK);
    drive();
    wait_done("update_toggle", 80);
    tog = 1'b0;
    wact[1] = 1'b0;
    ODataReady = 1'b1;
    drive();
    step();
    check("write_idle", {Grant, OCmdValid, ODataValid, ReqDataReady}, '0);

    // Requester 3 read-remove with its return path stalled for 5 cycles.
    stall_arm[3] = 1'b1;
    issue(3, BECMD_ReadRmv, 32'hC3);
    expect_read(3, BECMD_ReadRmv, 32'hC3);
    wait_done("readrmv_stall", 80);

    // All four hold Read: grant order 0,1,2,3,0.
    ncmd = 0;
    ncmd_stop = 5;
    for (int p = 0; p < N; p++) begin
      hold[p] = 1'b1;
      issue(p, BECMD_Read, 32'hD0 + AW'(p));
    end
    for (int i = 0; i < 5; i++) expect_read(i % N, BECMD_Read, 32'hD0 + AW'(i % N));
    wait_done("all_hold", 200);

    // Reset in the middle of a write block after 3 chunks.
    load_write(1, 64'h21);
    issue(1, BECMD_Update, 32'h61);
    expect_write(1, BECMD_Update, 32'h61, 64'h21, 3);
    drive();
    n = 0;
    while (wptr[1] < 3 && n < 40) begin
      step();
      n++;
    end
    if (wptr[1] < 3) begin
      vectors++;
      errors++;
      $display("FAIL timeout_midwrite: got %0d chunks expected 3", wptr[1]);
    end
    Reset   = 1'b1;
    wact[1] = 1'b0;
    drive();
    step();
    check("mid_reset_outs", {Grant, OCmdValid, ODataValid, ORetReady, ReqCmdReady, ReqDataReady, RespDataValid},
          '0);
    Reset = 1'b0;
    check("mid_reset_queue", 32'(exp_wd_q.size() + exp_cmd_q.size()), 32'd0);

    // After reset the pointer is 0: requester 1 append wins over requester 3.
    load_write(1, 64'h31);
    issue(1, BECMD_Append, 32'h71);
    issue(3, BECMD_Read, 32'hE3);
    expect_write(1, BECMD_Append, 32'h71, 64'h31, BLK);
    expect_read(3, BECMD_Read, 32'hE3);
    drive();
    wait_done("append_after_reset", 120);
    check("final_idle", {Grant, OCmdValid, ODataValid, ORetReady}, '0);
    check("queues_empty", 32'(exp_cmd_q.size() + exp_wd_q.size() + exp_rd_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
